// File: rtl/spm_serial_ctrl.sv
// Framing controller for the spm carry-save multiplier: loads x in parallel, streams y
// LSB first, and gathers the serial product bits into a 2W-bit word with handshakes on both sides.
module spm_serial_ctrl #(
  parameter int W      = 8,
  parameter int P_LAT  = 1,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  output logic [W-1:0]     spm_x,
  output logic             spm_y,
  output logic             spm_clr,
  input  logic             spm_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p
);

  localparam int PW  = 2 * W;
  localparam int LEN = PW + P_LAT;
  localparam int CW  = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   yext_q;
  logic            accept;
  logic            run_last;
  logic            cap_p;

  function automatic logic [PW-1:0] extend_y(input logic [W-1:0] y);
    logic signed [PW-1:0] y_s;
    if (SIGNED != 0) y_s = {{W{y[W-1]}}, y};
    else             y_s = {{W{1'b0}}, y};
    return y_s;
  endfunction

  assign accept   = in_valid && (state_q == IDLE);
  assign run_last = (state_q == RUN) && (cnt_q == CW'(LEN - 1));
  // The first P_LAT cycles of RUN only fill the array's pipeline; spm_p is not yet valid.
  assign cap_p    = (state_q == RUN) && (cnt_q >= CW'(P_LAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CLR;
      end
      CLR:  state_d = RUN;
      RUN:  if (run_last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spm_x   <= '0;
      spm_y   <= 1'b0;
      spm_clr <= 1'b0;
      out_p   <= '0;
      cnt_q   <= '0;
      yext_q  <= '0;
    end else begin
      spm_clr <= accept;
      // y is consumed from a shift register; zeros shifted in cover the c >= 2W tail.
      if (accept) begin
        spm_x  <= in_x;
        yext_q <= extend_y(in_y);
        spm_y  <= 1'b0;
      end else if ((state_q == CLR) || (state_q == RUN)) begin
        spm_y  <= yext_q[0];
        yext_q <= yext_q >> 1;
      end else begin
        spm_y  <= 1'b0;
      end

      if (state_q == CLR)      cnt_q <= '0;
      else if (state_q == RUN) cnt_q <= cnt_q + CW'(1);

      if (cap_p) out_p <= {spm_p, out_p[PW-1:1]};
    end
  end

endmodule

// File: tb/tb_spm_serial_ctrl.sv
// Scoreboard bench: one unsigned and one signed controller, each driving a behavioural
// spm array model with one cycle of product latency.
module tb_spm_serial_ctrl;

  localparam int W     = 8;
  localparam int P_LAT = 1;
  localparam int PW    = 2 * W;
  localparam int LAT   = PW + P_LAT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [W-1:0]  in_x      [2];
  logic [W-1:0]  in_y      [2];
  logic [W-1:0]  spm_x     [2];
  logic          spm_y     [2];
  logic          spm_clr   [2];
  logic          spm_p     [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [PW-1:0] out_p     [2];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int clr_cnt [2];
  int out_hs_edge [2];
  logic [PW-1:0] sbq0 [$];
  logic [PW-1:0] sbq1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic [PW-1:0] acc, xe, nxt;
    int            k;
    logic          p_q;

    spm_serial_ctrl #(.W(W), .P_LAT(P_LAT), .SIGNED(g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_x      (in_x[g]),
      .in_y      (in_y[g]),
      .spm_x     (spm_x[g]),
      .spm_y     (spm_y[g]),
      .spm_clr   (spm_clr[g]),
      .spm_p     (spm_p[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_p     (out_p[g])
    );

    // Array model: running partial-product sum; bit k is final once y bit k is added.
    assign xe  = (g == 1) ? {{W{spm_x[g][W-1]}}, spm_x[g]} : {{W{1'b0}}, spm_x[g]};
    assign nxt = acc + ((spm_y[g] && (k < PW)) ? (xe << k) : '0);
    assign spm_p[g] = p_q;

    always @(posedge clk) begin
      if (spm_clr[g]) begin
        acc <= '0;
        k   <= 0;
        p_q <= 1'b0;
      end else begin
        acc <= nxt;
        p_q <= (k < PW) ? nxt[k[3:0]] : 1'b0;
        k   <= (k < PW) ? k + 1 : k;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
  endtask

  function automatic logic [PW-1:0] ref_mul(input int g, input logic [W-1:0] x, input logic [W-1:0] y);
    int a, b;
    if (g == 1) begin
      a = int'($signed(x));
      b = int'($signed(y));
    end else begin
      a = int'(x);
      b = int'(y);
    end
    return PW'(a * b);
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (spm_clr[g]) clr_cnt[g] <= clr_cnt[g] + 1;
      if (!rst && out_valid[g] && out_ready[g]) begin
        out_hs_edge[g] <= cyc + 1;
        if (g == 0) begin
          if (sbq0.size() == 0) check("sb_underflow_u", sbq0.size(), 1);
          else check("product_u", out_p[0], sbq0.pop_front());
        end else begin
          if (sbq1.size() == 0) check("sb_underflow_s", sbq1.size(), 1);
          else check("product_s", out_p[1], sbq1.pop_front());
        end
      end
    end
  end

  task automatic send(input int g, input logic [W-1:0] x, input logic [W-1:0] y, output int acc_edge);
    in_x[g] = x;
    in_y[g] = y;
    in_valid[g] = 1'b1;
    acc_edge = -1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready[g]) begin
        if (g == 0) sbq0.push_back(ref_mul(0, x, y));
        else        sbq1.push_back(ref_mul(1, x, y));
        @(posedge clk); #1;
        acc_edge = cyc;
        in_valid[g] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid[g] = 1'b0;
    check("accept_timeout", in_ready[g], 1);
  endtask

  task automatic wait_done(input int g, output int e_n);
    e_n = -1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid[g]) begin
        e_n = cyc;
        return;
      end
      @(posedge clk); #1;
    end
    check("done_timeout", out_valid[g], 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sbq0.size() == 0 && sbq1.size() == 0) return;
      @(posedge clk); #1;
    end
    check("drain_timeout", sbq0.size() + sbq1.size(), 0);
  endtask

  logic [W-1:0] bx [4] = '{8'h11, 8'hC3, 8'h00, 8'h7F};
  logic [W-1:0] by [4] = '{8'h22, 8'h5A, 8'hEE, 8'h81};

  initial begin
    int acc, e, c0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      in_x[g] = '0;
      in_y[g] = '0;
      out_ready[g] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready[0], 1);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_spm_clr", spm_clr[0], 0);
    check("rst_spm_y", spm_y[0], 0);
    check("rst_spm_x", spm_x[0], 0);
    check("rst_out_p", out_p[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    c0 = clr_cnt[0];
    send(0, 8'd3, 8'd5, acc);
    check("clr_after_accept", spm_clr[0], 1);
    check("busy_in_ready", in_ready[0], 0);
    wait_done(0, e);
    check("latency", e - acc, LAT);
    check("clr_pulses", clr_cnt[0] - c0, 1);
    check("done_out_p", out_p[0], 16'h000F);

    send(0, 8'hFF, 8'hFF, acc);
    send(1, 8'hFD, 8'h05, acc);
    send(1, 8'h80, 8'h80, acc);
    drain();

    out_ready[0] = 1'b0;
    send(0, 8'hA5, 8'h3C, acc);
    wait_done(0, e);
    in_valid[0] = 1'b1;
    in_x[0] = 8'h01;
    in_y[0] = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid[0], 1);
      check("bp_out_p", out_p[0], ref_mul(0, 8'hA5, 8'h3C));
      check("bp_in_ready", in_ready[0], 0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid[0], 0);
    check("bp_release_idle", in_ready[0], 1);

    for (int i = 0; i < 4; i++) begin
      send(0, bx[i], by[i], acc);
      if (i > 0) check("b2b_gap", acc - out_hs_edge[0], 1);
    end
    drain();

    send(0, 8'h55, 8'hFF, acc);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid[0], 0);
    check("arst_spm_clr", spm_clr[0], 0);
    check("arst_spm_y", spm_y[0], 0);
    check("arst_spm_x", spm_x[0], 0);
    check("arst_out_p", out_p[0], 0);
    check("arst_in_ready", in_ready[0], 1);
    sbq0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 8'd7, 8'd9, acc);
    drain();

    send(0, 8'h12, 8'h34, acc);
    for (int i = 0; i < LAT; i++) begin
      in_x[0] = 8'($urandom);
      in_y[0] = 8'($urandom);
      @(posedge clk); #1;
      check("spm_x_hold", spm_x[0], 8'h12);
    end
    drain();

    check("sb_empty_u", sbq0.size(), 0);
    check("sb_empty_s", sbq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
